// File: rtl/regf_dp_d0w_dnr_clr_if.sv
// Bus bundle for the multi-read-port register file: one write port, N_RD read
// ports, clear request and busy flag.
interface regf_dp_d0w_dnr_clr_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned N_RD       = 2
);
    logic                       clr;
    logic                       busy;
    logic [ADDR_WIDTH-1:0]      address_0;
    logic [DATA_WIDTH-1:0]      data_0;
    logic                       we_0;
    logic [N_RD*ADDR_WIDTH-1:0] address_1;
    logic [N_RD-1:0]            rd_1;
    logic [N_RD*DATA_WIDTH-1:0] data_1;
    logic [N_RD-1:0]            valid_1;

    modport master (
        output clr, address_0, data_0, we_0, address_1, rd_1,
        input  busy, data_1, valid_1
    );

    modport slave (
        input  clr, address_0, data_0, we_0, address_1, rd_1,
        output busy, data_1, valid_1
    );
endinterface

// File: rtl/regf_dp_d0w_dnr_clr.sv
// Register file with one write port, N_RD registered read ports, optional
// write-first bypass and a sweep engine that zeroes every entry after reset/clr.
module regf_dp_d0w_dnr_clr #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned REGF_DEPTH = 1 << ADDR_WIDTH,
    parameter int unsigned N_RD       = 2,
    parameter int unsigned BYPASS     = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    regf_dp_d0w_dnr_clr_if.slave bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(REGF_DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(REGF_DEPTH - 1);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [N_RD*DW-1:0]   data_1_q, data_1_d;
    logic [N_RD-1:0]      valid_1_q, valid_1_d;
    logic [DW-1:0]        regf_q [0:REGF_DEPTH-1];
    logic [DW-1:0]        regf_d [0:REGF_DEPTH-1];
    logic                 wr_ok_c;
    logic [AW-1:0]        rd_addr_c;
    logic [DW-1:0]        rd_val_c;

    // A write lands only when idle, not pre-empted by clr, and in range.
    assign wr_ok_c = (state_q == ST_IDLE) && !bus.clr && bus.we_0
                     && ({1'b0, bus.address_0} < DEPTH_W);

    // State register plus control/output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            data_1_q  <= '0;
            valid_1_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            data_1_q  <= data_1_d;
            valid_1_q <= valid_1_d;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            regf_q <= regf_d;
        end
    end

    // Next-state: sweep to the last entry, or restart on clr.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs and array update; reads sample the array before this cycle's write.
    always_comb begin
        busy_d    = (state_d == ST_CLEAR);
        valid_1_d = '0;
        data_1_d  = data_1_q;
        regf_d    = regf_q;
        rd_addr_c = '0;
        rd_val_c  = '0;
        if (state_q == ST_CLEAR) begin
            regf_d[cnt_q] = '0;
        end else begin
            for (int i = 0; i < int'(N_RD); i++) begin
                if (bus.rd_1[i]) begin
                    rd_addr_c = bus.address_1[i*AW +: AW];
                    rd_val_c  = ({1'b0, rd_addr_c} < DEPTH_W) ? regf_q[rd_addr_c] : '0;
                    if ((BYPASS != 0) && wr_ok_c && (rd_addr_c == bus.address_0)) begin
                        rd_val_c = bus.data_0;
                    end
                    valid_1_d[i]          = 1'b1;
                    data_1_d[i*DW +: DW]  = rd_val_c;
                end
            end
            if (wr_ok_c) begin
                regf_d[bus.address_0] = bus.data_0;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.data_1  = data_1_q;
    assign bus.valid_1 = valid_1_q;
endmodule

// File: tb/tb_regf_dp_d0w_dnr_clr.sv
// Bench: two instances (DEPTH=8/write-first, DEPTH=6/read-first) share one
// directed stimulus stream and are compared every cycle against a behavioural model.
module tb_regf_dp_d0w_dnr_clr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       we    = 1'b0;
    logic [2:0] a0    = '0;
    logic [7:0] d0    = '0;
    logic [5:0] a1    = '0;
    logic [1:0] rd    = '0;

    regf_dp_d0w_dnr_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .N_RD(2)) ifa ();
    regf_dp_d0w_dnr_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .N_RD(2)) ifb ();

    assign ifa.clr = clr;  assign ifa.we_0 = we;  assign ifa.address_0 = a0;
    assign ifa.data_0 = d0; assign ifa.address_1 = a1; assign ifa.rd_1 = rd;
    assign ifb.clr = clr;  assign ifb.we_0 = we;  assign ifb.address_0 = a0;
    assign ifb.data_0 = d0; assign ifb.address_1 = a1; assign ifb.rd_1 = rd;

    regf_dp_d0w_dnr_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .REGF_DEPTH(8), .N_RD(2), .BYPASS(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    regf_dp_d0w_dnr_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .REGF_DEPTH(6), .N_RD(2), .BYPASS(0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: instance k has depth dep[k]; rem = clear cycles still to run.
    int         dep [2] = '{8, 6};
    bit         byp [2] = '{1'b1, 1'b0};
    logic [7:0] mem [2][8];
    int         rem [2];
    logic [15:0] m_data [2];
    logic [1:0]  m_valid [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rem[k] = dep[k];
                m_data[k] = '0;
                m_valid[k] = '0;
                for (int j = 0; j < 8; j++) mem[k][j] = '0;
            end else if (rem[k] > 0) begin
                rem[k]--;
                m_valid[k] = '0;
            end else begin
                bit wr_ok;
                wr_ok = we && !clr && (int'(a0) < dep[k]);
                for (int p = 0; p < 2; p++) begin
                    int ra;
                    logic [7:0] v;
                    m_valid[k][p] = rd[p];
                    if (rd[p]) begin
                        ra = int'(a1[p*3 +: 3]);
                        v  = (ra < dep[k]) ? mem[k][ra] : 8'h00;
                        if (wr_ok && byp[k] && ra == int'(a0)) v = d0;
                        m_data[k][p*8 +: 8] = v;
                    end
                end
                if (clr) begin
                    rem[k] = dep[k];
                    for (int j = 0; j < 8; j++) mem[k][j] = '0;
                end else if (wr_ok) begin
                    mem[k][a0] = d0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_busy",  {31'd0, ifa.busy}, {31'd0, rem[0] > 0});
            chk("a_valid", {30'd0, ifa.valid_1}, {30'd0, m_valid[0]});
            chk("a_data",  {16'd0, ifa.data_1}, {16'd0, m_data[0]});
            chk("b_busy",  {31'd0, ifb.busy}, {31'd0, rem[1] > 0});
            chk("b_valid", {30'd0, ifb.valid_1}, {30'd0, m_valid[1]});
            chk("b_data",  {16'd0, ifb.data_1}, {16'd0, m_data[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; a0 = a; d0 = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rdp(input logic [2:0] r0, input logic [2:0] r1);
        rd = 2'b11; a1 = {r1, r0};
        cyc();
        rd = 2'b00;
    endtask

    // Counts busy samples over a fixed window starting now.
    task automatic count_busy(output int na, output int nb, input bit poke);
        na = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            rd = poke ? 2'b11 : 2'b00;
            we = poke && (i < 5);
            a0 = 3'd0; d0 = 8'h99; a1 = {3'd1, 3'd0};
            if (ifa.busy) na++;
            if (ifb.busy) nb++;
            cyc();
        end
        rd = '0; we = 1'b0;
    endtask

    initial begin
        int na, nb;
        cyc();
        chk_en = 1'b1;
        chk("rst_a_data", {16'd0, ifa.data_1}, 32'h0);
        chk("rst_a_busy", {31'd0, ifa.busy}, 32'h1);
        cyc(); cyc();
        rst_n = 1'b1;
        count_busy(na, nb, 1'b0);
        chk("rel_busy_a_len", na, 8);
        chk("rel_busy_b_len", nb, 6);
        for (int i = 0; i < 8; i++) rdp(3'(i), 3'(7 - i));
        chk("zero_a_valid", {30'd0, ifa.valid_1}, 32'h3);

        // Basic write then dual read.
        wr(3'd3, 8'hA5);
        wr(3'd6, 8'h3C);
        rdp(3'd3, 3'd6);
        chk("wrrd_a", {16'd0, ifa.data_1}, 32'h3CA5);
        chk("wrrd_b", {16'd0, ifb.data_1}, 32'h00A5);
        chk("wrrd_a_valid", {30'd0, ifa.valid_1}, 32'h3);

        // Same-cycle write/read on address 2.
        wr(3'd2, 8'h11);
        we = 1'b1; a0 = 3'd2; d0 = 8'h77; rd = 2'b01; a1 = {3'd0, 3'd2};
        cyc();
        we = 1'b0; rd = 2'b00;
        chk("byp_a", {24'd0, ifa.data_1[7:0]}, 32'h77);
        chk("byp_b", {24'd0, ifb.data_1[7:0]}, 32'h11);
        rdp(3'd2, 3'd2);
        chk("after_byp_a", {16'd0, ifa.data_1}, 32'h7777);
        chk("after_byp_b", {16'd0, ifb.data_1}, 32'h7777);

        // Fill then clear with a competing write.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
        clr = 1'b1; we = 1'b1; a0 = 3'd1; d0 = 8'h42; rd = 2'b11; a1 = {3'd7, 3'd1};
        cyc();
        clr = 1'b0; we = 1'b0; rd = 2'b00;
        chk("clr_rd_a", {16'd0, ifa.data_1}, 32'hFFFF);
        chk("clr_rd_b", {16'd0, ifb.data_1}, 32'h00FF);
        count_busy(na, nb, 1'b1);
        chk("clr_busy_a_len", na, 8);
        chk("clr_busy_b_len", nb, 6);
        for (int i = 0; i < 8; i++) rdp(3'(i), 3'(i));
        rdp(3'd1, 3'd0);
        chk("clr_addr1_a", {16'd0, ifa.data_1}, 32'h0);

        // Reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h20 + i));
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        count_busy(na, nb, 1'b0);
        chk("mid_busy_a_len", na, 8);
        chk("mid_busy_b_len", nb, 6);
        for (int i = 0; i < 8; i++) rdp(3'(i), 3'(7 - i));

        // Out-of-range write on the 6-deep instance.
        for (int i = 0; i < 6; i++) wr(3'(i), 8'(8'h10 + i));
        wr(3'd7, 8'h5A);
        rdp(3'd7, 3'd5);
        chk("oor_b", {16'd0, ifb.data_1}, 32'h1500);
        chk("oor_a", {16'd0, ifa.data_1}, 32'h155A);
        for (int i = 0; i < 6; i++) rdp(3'(i), 3'(i));
        cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
